aes_256_ctr_feeder: RTL and testbench

- Upstream and downstream control stage for the pipelined aes_256 cipher core (LATENCY-cycle, no stall), turning it into an AES-256 counter-mode stream engine.
- Generates counter blocks {nonce, ctr} and the key for the core.
- Delays each accepted data block to align with the core's keystream output, XORs the two, and buffers the result in an output FIFO.
- Provides valid/ready flow control on both sides. The core cannot stall, so backpressure is handled with credit accounting.

---
 rtl/aes_256_ctr_feeder_if.sv | 23 ++
 rtl/aes_256_ctr_feeder.sv | 179 +++++++++++++++++
 tb/tb_aes_256_ctr_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_256_ctr_feeder_if.sv
// Stream handshake bundle for aes_256_ctr_feeder.
//   in_valid/in_ready/in_data    : input blocks (plaintext or ciphertext)
//   out_valid/out_ready/out_data : result blocks (in_data XOR keystream)
// master : block source and result consumer (drives in_*, out_ready)
// slave  : the feeder (drives in_ready, out_valid, out_data)
interface aes_256_ctr_feeder_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_256_ctr_feeder.sv
// AES-256 counter-mode front/back end for a fixed-latency, non-stalling
// pipelined cipher core. It feeds {nonce, ctr} and the key to the core,
// delays each accepted block by LATENCY cycles so that it meets its
// keystream, XORs the two and queues the result in a show-ahead FIFO.
// Because the core cannot stall, input acceptance is limited by credits:
// a block is only taken when a FIFO slot is reserved for it.
//
// Ports:
//   clk, clr_n          clock, asynchronous active-low reset
//   key_load            capture key_in / iv_in (ignored while busy)
//   key_in, iv_in       256-bit key, {nonce, initial counter}
//   busy                blocks in flight or FIFO non-empty
//   ctr_wrap            sticky counter wrap flag, cleared by a load
//   core_dat_in         counter block to the cipher core
//   core_key            key to the cipher core
//   core_dat_out        keystream from the cipher core
//   bus                 input/output stream handshake (slave side)
module aes_256_ctr_feeder #(
  parameter int unsigned LATENCY    = 14,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CTR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  key_load,
  input  logic [255:0]          key_in,
  input  logic [127:0]          iv_in,
  output logic                  busy,
  output logic                  ctr_wrap,
  output logic [127:0]          core_dat_in,
  output logic [255:0]          core_key,
  input  logic [127:0]          core_dat_out,
  aes_256_ctr_feeder_if.slave   bus
);

  localparam int unsigned NW = 128 - CTR_WIDTH;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic                 loaded;
  logic [255:0]         key_reg;
  logic [NW-1:0]        nonce;
  logic [CTR_WIDTH-1:0] ctr;
  logic                 wrap_q;

  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        inflight;
  logic [CW:0]          used;
  logic                 accept;
  logic                 load_en;
  logic                 exit_v;
  logic [127:0]         exit_d;
  logic                 push;
  logic                 pop;
  logic [127:0]         push_data;

  logic [127:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  assign core_key    = key_reg;
  assign core_dat_in = {nonce, ctr};
  assign ctr_wrap    = wrap_q;

  assign busy    = (inflight != '0) || (fifo_count != '0);
  assign load_en = key_load && !busy;

  // Every block in the delay line already owns a FIFO slot, so the
  // remaining credit is whatever neither the FIFO nor the line holds.
  assign used          = {1'b0, fifo_count} + {1'b0, inflight};
  assign bus.in_ready  = loaded && !key_load && (used < (CW+1)'(FIFO_DEPTH));
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      loaded  <= 1'b0;
      key_reg <= '0;
      nonce   <= '0;
      ctr     <= '0;
      wrap_q  <= 1'b0;
    end else if (load_en) begin
      key_reg <= key_in;
      nonce   <= iv_in[127:CTR_WIDTH];
      ctr     <= iv_in[CTR_WIDTH-1:0];
      loaded  <= 1'b1;
      wrap_q  <= 1'b0;
    end else if (accept) begin
      ctr <= ctr + CTR_WIDTH'(1);
      if (ctr == '1) begin
        wrap_q <= 1'b1;
      end
    end
  end

  // Delay line aligning each data block with its keystream.
  if (LATENCY == 0) begin : g_no_delay
    assign exit_v = accept;
    assign exit_d = bus.in_data;
  end else begin : g_delay
    logic [LATENCY-1:0] dly_v;
    logic [127:0]       dly_d [LATENCY];

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        dly_v <= '0;
      end else begin
        dly_v[0] <= accept;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          dly_v[i] <= dly_v[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      dly_d[0] <= bus.in_data;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        dly_d[i] <= dly_d[i-1];
      end
    end

    assign exit_v = dly_v[LATENCY-1];
    assign exit_d = dly_d[LATENCY-1];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      inflight <= '0;
    end else begin
      case ({accept, exit_v})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign push      = exit_v;
  assign push_data = exit_d ^ core_dat_out;

  // Output FIFO, show-ahead.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credit accounting guarantees a free slot for every exiting block.
  a_no_overflow: assert property (@(posedge clk) disable iff (!clr_n)
    !(push && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_aes_256_ctr_feeder.sv
// Self-checking bench for aes_256_ctr_feeder. A behavioural AES-256 core
// with a LATENCY-stage output pipe is attached; a scoreboard queue holds
// the expected output for every accepted block.
module tb_aes_256_ctr_feeder;
  localparam int LATENCY    = 14;
  localparam int FIFO_DEPTH = 16;
  localparam int CTR_WIDTH  = 32;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         key_load;
  logic [255:0] key_in;
  logic [127:0] iv_in;
  logic         busy;
  logic         ctr_wrap;
  logic [127:0] core_dat_in;
  logic [255:0] core_key;
  logic [127:0] core_dat_out;

  aes_256_ctr_feeder_if bus ();

  aes_256_ctr_feeder #(
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CTR_WIDTH (CTR_WIDTH)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .key_load    (key_load),
    .key_in      (key_in),
    .iv_in       (iv_in),
    .busy        (busy),
    .ctr_wrap    (ctr_wrap),
    .core_dat_in (core_dat_in),
    .core_key    (core_key),
    .core_dat_out(core_dat_out),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // ---------------- AES-256 reference ----------------
  bit [7:0] sbox [256];

  function automatic bit [7:0] gmul(bit [7:0] a, bit [7:0] b);
    bit [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic bit [7:0] rotl8(bit [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      bit [7:0] inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic bit [31:0] subw(bit [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  function automatic bit [127:0] aes256(bit [255:0] key, bit [127:0] pt);
    bit [31:0]  w [60];
    bit [31:0]  t;
    bit [7:0]   rc = 8'h01;
    bit [7:0]   s [16];
    bit [7:0]   n [16];
    bit [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) n[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(n[4*c], 2) ^ gmul(n[4*c+1], 3) ^ n[4*c+2] ^ n[4*c+3];
          s[4*c+1] = n[4*c] ^ gmul(n[4*c+1], 2) ^ gmul(n[4*c+2], 3) ^ n[4*c+3];
          s[4*c+2] = n[4*c] ^ n[4*c+1] ^ gmul(n[4*c+2], 2) ^ gmul(n[4*c+3], 3);
          s[4*c+3] = gmul(n[4*c], 3) ^ n[4*c+1] ^ n[4*c+2] ^ gmul(n[4*c+3], 2);
        end
      end else begin
        s = n;
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Pipelined core model: keystream appears LATENCY edges after its input.
  logic [127:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= aes256(core_key, core_dat_in);
    for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
  end
  assign core_dat_out = pipe[LATENCY-1];

  // ---------------- scoreboard and checking ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_acc  = 0;
  logic send_en;

  logic [255:0] m_key;
  logic [95:0]  m_nonce;
  logic [31:0]  m_ctr;
  logic         m_loaded;
  logic         m_wrap;

  logic [127:0] tx_q  [$];
  logic [127:0] exp_q [$];
  logic [127:0] rx_q  [$];
  int           acc_cyc [$];
  int           pop_cyc [$];

  function automatic void check(string tag, logic [255:0] obs, logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle();
    logic exp_rdy;
    logic exp_busy;
    bus.in_valid = send_en && (tx_q.size() != 0);
    bus.in_data  = bus.in_valid ? tx_q[0] : '0;
    #1;
    exp_busy = (exp_q.size() != 0);
    exp_rdy  = m_loaded && !key_load && (exp_q.size() < FIFO_DEPTH);
    check("in_ready", bus.in_ready, exp_rdy);
    check("busy", busy, exp_busy);
    check("ctr_wrap", ctr_wrap, m_wrap);
    if (bus.out_valid && bus.out_ready) begin
      check("out_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
      rx_q.push_back(bus.out_data);
      pop_cyc.push_back(cyc);
    end
    if (bus.in_valid && bus.in_ready) begin
      check("core_dat_in", core_dat_in, {m_nonce, m_ctr});
      check("core_key", core_key, m_key);
      exp_q.push_back(tx_q[0] ^ aes256(m_key, {m_nonce, m_ctr}));
      if (m_ctr == 32'hffffffff) m_wrap = 1'b1;
      m_ctr = m_ctr + 32'd1;
      void'(tx_q.pop_front());
      acc_cyc.push_back(cyc);
      n_acc++;
    end
    if (key_load && !exp_busy) begin
      m_key    = key_in;
      m_nonce  = iv_in[127:32];
      m_ctr    = iv_in[31:0];
      m_loaded = 1'b1;
      m_wrap   = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic load(input logic [255:0] k, input logic [127:0] iv);
    key_in   = k;
    iv_in    = iv;
    key_load = 1'b1;
    cycle();
    key_load = 1'b0;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((exp_q.size() != 0 || tx_q.size() != 0) && k < bound) begin
      cycle();
      k++;
    end
    check("drain_in_time", k < bound, 1'b1);
  endtask

  task automatic reset_model();
    m_key = '0; m_nonce = '0; m_ctr = '0; m_loaded = 1'b0; m_wrap = 1'b0;
    tx_q.delete(); exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"}, bus.out_data, 128'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ctr_wrap"}, ctr_wrap, 1'b0);
    check({tag, "_core_dat_in"}, core_dat_in, 128'h0);
    check({tag, "_core_key"}, core_key, 256'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] IV_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_B = 256'hdeadbeef_01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_cafef00d;
  localparam logic [127:0] IV_B  = 128'h0badf00d_13572468_aaaa5555_ffffffff;

  initial begin
    logic [127:0] pt [20];
    logic [127:0] ct [20];
    int base;

    clr_n = 1'b0; key_load = 1'b0; key_in = '0; iv_in = '0; send_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    clr_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.3 keystream, latency and counter increment
    bus.out_ready = 1'b1;
    load(KEY_A, IV_A);
    tx_q.push_back('0);
    send_en = 1'b1;
    cycle();
    check("fips_next_ctr", core_dat_in, 128'h00112233445566778899aabbccddef00);
    for (int k = 0; k < 50 && !bus.out_valid; k++) cycle();
    check("fips_latency_edges", cyc - acc_cyc[acc_cyc.size()-1], LATENCY + 1);
    check("fips_keystream", bus.out_data, 128'h8ea2b7ca516745bfeafc49904b496089);
    drain(50);

    // 40 back-to-back blocks at full rate
    acc_cyc.delete(); pop_cyc.delete();
    for (int i = 0; i < 40; i++) tx_q.push_back({$urandom, $urandom, $urandom, $urandom});
    drain(200);
    check("stream_acc_count", acc_cyc.size(), 40);
    check("stream_pop_count", pop_cyc.size(), 40);
    check("stream_acc_gapless", acc_cyc[39] - acc_cyc[0], 39);
    check("stream_pop_gapless", pop_cyc[39] - pop_cyc[0], 39);

    // Backpressure: only FIFO_DEPTH blocks may be taken
    bus.out_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 20; i++) tx_q.push_back({$urandom, $urandom, $urandom, $urandom});
    run(40);
    check("bp_accepted", n_acc - base, FIFO_DEPTH);
    check("bp_left", tx_q.size(), 4);
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    drain(200);
    check("bp_all_out", n_acc - base, 20);

    // Counter wrap
    load(KEY_B, IV_B);
    tx_q.push_back(128'h1);
    cycle();
    check("wrap_ctr_low", core_dat_in[31:0], 32'h0);
    check("wrap_flag", ctr_wrap, 1'b1);
    tx_q.push_back(128'h2);
    drain(50);
    load(KEY_B, IV_A);
    check("wrap_cleared", ctr_wrap, 1'b0);

    // Load while busy is ignored; ciphertexts then decrypt back
    load(KEY_A, IV_B);
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      pt[i] = {$urandom, $urandom, $urandom, $urandom};
      tx_q.push_back(pt[i]);
    end
    run(8);
    check("busy_load_busy", busy, 1'b1);
    load(KEY_B, IV_A);
    drain(200);
    check("busy_load_key_kept", core_key, KEY_A);
    check("rt_ct_count", rx_q.size(), 20);
    for (int i = 0; i < 20; i++) ct[i] = rx_q[i];
    load(KEY_A, IV_B);
    rx_q.delete();
    for (int i = 0; i < 20; i++) tx_q.push_back(ct[i]);
    drain(200);
    for (int i = 0; i < 20; i++) check("rt_plain", rx_q[i], pt[i]);

    // Reset mid-stream
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tx_q.push_back({$urandom, $urandom, $urandom, $urandom});
    run(18);
    check("pre_reset_out_valid", bus.out_valid, 1'b1);
    check("pre_reset_busy", busy, 1'b1);
    clr_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    reset_model();
    @(negedge clk);
    clr_n = 1'b1;
    base = n_acc;
    for (int i = 0; i < 4; i++) tx_q.push_back({$urandom, $urandom, $urandom, $urandom});
    bus.out_ready = 1'b1;
    run(5);
    check("post_reset_no_accept", n_acc - base, 0);
    load(KEY_B, IV_B);
    drain(100);
    check("post_reset_resumed", n_acc - base, 4);

    send_en = 1'b0;
    bus.in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
